// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer capture path.
// The trigger-mode encoding is shared with the top-level mode decode.
package la_pkg;

  localparam int LA_MAX_CH = 8;

  localparam logic LA_TRIG_LEVEL = 1'b0;
  localparam logic LA_TRIG_EDGE  = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    READ = 3'd4
  } la_state_t;

  // Edge mode fires only on a fresh match, so a pattern that is already present cannot re-fire.
  function automatic logic la_fire(input logic mode, input logic match, input logic prev_match);
    la_fire = (mode == LA_TRIG_LEVEL) ? match
            : ((mode == LA_TRIG_EDGE) && match && !prev_match);
  endfunction

endpackage

// File: rtl/la_capture_engine_if.sv
// Readout stream of the capture engine: one buffer word per beat, oldest first.
interface la_capture_engine_if #(
  parameter int CH = 4
);
  logic [CH-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/la_trig_match.sv
// Masked level/edge trigger compare; keeps the match result of the previous sample.
module la_trig_match
  import la_pkg::*;
#(
  parameter int CH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in_data_i,
  input  logic [CH-1:0] trig_mask_i,
  input  logic [CH-1:0] trig_value_i,
  input  logic          trig_edge_i,
  input  logic          strobe_en_i,
  input  logic          preset_i,
  input  logic          eval_i,
  output logic          fire_o
);

  logic [LA_MAX_CH-1:0] diff;
  logic                 match;
  logic                 prev_match_q;

  assign diff  = LA_MAX_CH'((in_data_i ^ trig_value_i) & trig_mask_i);
  assign match = (diff == '0);

  // Preset to 1 on arm so an input already matching cannot produce an edge trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_match_q <= 1'b1;
    end else if (preset_i) begin
      prev_match_q <= 1'b1;
    end else if (strobe_en_i) begin
      prev_match_q <= match;
    end
  end

  assign fire_o = eval_i && strobe_en_i && la_fire(trig_edge_i, match, prev_match_q);

endmodule

// File: rtl/la_capture_engine.sv
// Programmable-rate capture into a circular buffer with pre-trigger history,
// frozen on trigger and streamed out oldest-first.
module la_capture_engine
  import la_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DEPTH = 16,
  parameter int PRE   = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    in_data,
  input  logic             arm,
  input  logic             abort,
  input  logic [DIV_W-1:0] div,
  input  logic [CH-1:0]    trig_mask,
  input  logic [CH-1:0]    trig_value,
  input  logic             trig_edge,
  output logic             busy,
  output logic             triggered,
  la_capture_engine_if.master rd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_FILL = FILL;
  localparam logic [2:0] ST_WAIT = WAIT;
  localparam logic [2:0] ST_POST = POST;
  localparam logic [2:0] ST_READ = READ;

  localparam logic [CW-1:0] PRE_N  = CW'(PRE);
  localparam logic [CW-1:0] POST_N = CW'(DEPTH - PRE);
  localparam logic [AW-1:0] LAST_N = AW'(DEPTH - 1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_lim_q, div_lim_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    smp_cnt_q, smp_cnt_d;
  logic [AW-1:0]    beat_q, beat_d;
  logic             trig_q, trig_d;

  logic [CH-1:0]    mem_q [DEPTH];

  logic capturing;
  logic strobe;
  logic arm_ok;
  logic fire;
  logic rd_valid;
  logic xfer;

  assign capturing = (state_q == ST_FILL) || (state_q == ST_WAIT) || (state_q == ST_POST);
  assign strobe    = capturing && (div_cnt_q == div_lim_q);
  assign arm_ok    = arm && !abort && (state_q == ST_IDLE);
  assign rd_valid  = (state_q == ST_READ);
  assign xfer      = rd_valid && rd.rd_ready;

  la_trig_match #(
    .CH (CH)
  ) u_trig (
    .clk          (clk),
    .rst          (rst),
    .in_data_i    (in_data),
    .trig_mask_i  (trig_mask),
    .trig_value_i (trig_value),
    .trig_edge_i  (trig_edge),
    .strobe_en_i  (strobe),
    .preset_i     (arm_ok),
    .eval_i       (state_q == ST_WAIT),
    .fire_o       (fire)
  );

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    div_lim_d = div_lim_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    smp_cnt_d = smp_cnt_q;
    beat_d    = beat_q;
    trig_d    = trig_q;

    // The divider limit is only reloaded on a wrap, so a new div never shortens a period.
    if (capturing) begin
      if (strobe) begin
        div_cnt_d = '0;
        div_lim_d = div;
        wr_ptr_d  = wr_ptr_q + AW'(1);
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (arm_ok) begin
          div_cnt_d = '0;
          div_lim_d = div;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          smp_cnt_d = '0;
          beat_d    = '0;
          trig_d    = 1'b0;
          state_d   = (PRE == 0) ? ST_WAIT : ST_FILL;
        end
      end
      ST_FILL: begin
        if (strobe) begin
          smp_cnt_d = smp_cnt_q + CW'(1);
          if (smp_cnt_q + CW'(1) == PRE_N) begin
            smp_cnt_d = '0;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (fire) begin
          trig_d    = 1'b1;
          smp_cnt_d = CW'(1);
          if (POST_N == CW'(1)) begin
            rd_ptr_d = wr_ptr_q + AW'(1);
            state_d  = ST_READ;
          end else begin
            state_d  = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (strobe) begin
          smp_cnt_d = smp_cnt_q + CW'(1);
          if (smp_cnt_q + CW'(1) == POST_N) begin
            rd_ptr_d = wr_ptr_q + AW'(1);
            state_d  = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (xfer) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          beat_d   = beat_q + AW'(1);
          if (beat_q == LAST_N) begin
            beat_d  = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort outranks arm, trigger and readout in the same cycle.
    if (abort) begin
      state_d = ST_IDLE;
      trig_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      div_lim_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      smp_cnt_q <= '0;
      beat_q    <= '0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      div_lim_q <= div_lim_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      smp_cnt_q <= smp_cnt_d;
      beat_q    <= beat_d;
      trig_q    <= trig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (strobe) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign busy        = capturing;
  assign triggered   = trig_q;
  assign rd.rd_valid = rd_valid;
  assign rd.rd_last  = rd_valid && (beat_q == LAST_N);
  assign rd.rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_la_capture_engine.sv
// Directed bench for la_capture_engine: table of capture scenarios plus corner sequences.
module tb_la_capture_engine;

  typedef struct {
    logic [7:0] dv;
    logic [3:0] mask;
    logic [3:0] val;
    logic       edg;
    logic [3:0] first;
    logic [3:0] step;
    logic       tog;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic       arm, abort;
  logic [7:0] div;
  logic [3:0] trig_mask, trig_value;
  logic       trig_edge;
  logic       busy, triggered;
  logic       arm0, abort0;
  logic       busy0, triggered0;
  logic       ramp;

  int nvec;
  int nfail;

  la_capture_engine_if #(.CH(4)) rdif ();
  la_capture_engine_if #(.CH(4)) rdif0 ();

  la_capture_engine #(.CH(4), .DEPTH(16), .PRE(4), .DIV_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .arm        (arm),
    .abort      (abort),
    .div        (div),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_edge  (trig_edge),
    .busy       (busy),
    .triggered  (triggered),
    .rd         (rdif.master)
  );

  la_capture_engine #(.CH(4), .DEPTH(16), .PRE(0), .DIV_W(8)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .arm        (arm0),
    .abort      (abort0),
    .div        (div),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_edge  (trig_edge),
    .busy       (busy0),
    .triggered  (triggered0),
    .rd         (rdif0.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp) in_data = in_data + 4'd1;
  endtask

  task automatic wait_read(output logic ok);
    int n;
    n = 0;
    while (!rdif.rd_valid && n < 400) begin
      tick();
      n++;
    end
    ok = rdif.rd_valid;
    chk("reach_read", {31'd0, ok}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   beat;
    int   cyc;
    logic ok;
    logic [3:0] e;
    div        = v.dv;
    trig_mask  = v.mask;
    trig_value = v.val;
    trig_edge  = v.edg;
    in_data    = 4'h0;
    ramp       = 1'b1;
    arm        = 1'b1;
    tick();
    arm = 1'b0;
    wait_read(ok);
    if (!ok) return;
    chk($sformatf("v%0d_trig", idx), {31'd0, triggered}, 32'd1);
    chk($sformatf("v%0d_busy_rd", idx), {31'd0, busy}, 32'd0);
    beat = 0;
    cyc  = 0;
    while (beat < 16 && cyc < 100) begin
      rdif.rd_ready = v.tog ? ((cyc % 2) == 0) : 1'b1;
      e = v.first + 4'(beat) * v.step;
      chk($sformatf("v%0d_valid_b%0d", idx, beat), {31'd0, rdif.rd_valid}, 32'd1);
      chk($sformatf("v%0d_data_b%0d", idx, beat), {28'd0, rdif.rd_data}, {28'd0, e});
      chk($sformatf("v%0d_last_b%0d", idx, beat), {31'd0, rdif.rd_last}, (beat == 15) ? 32'd1 : 32'd0);
      tick();
      if (rdif.rd_ready) beat++;
      cyc++;
    end
    rdif.rd_ready = 1'b0;
    ramp = 1'b0;
    chk($sformatf("v%0d_beats", idx), beat, 16);
    chk($sformatf("v%0d_end_valid", idx), {31'd0, rdif.rd_valid}, 32'd0);
    chk($sformatf("v%0d_end_busy", idx), {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    logic ok;
    int   n;

    // div, mask, value, edge, first window word, spacing, ready toggling
    vecs[0] = '{8'd0, 4'hF, 4'h9, 1'b0, 4'h5, 4'h1, 1'b0};
    vecs[1] = '{8'd3, 4'hF, 4'hC, 1'b0, 4'hC, 4'h4, 1'b0};
    vecs[2] = '{8'd0, 4'h3, 4'h2, 1'b0, 4'h2, 4'h1, 1'b0};
    vecs[3] = '{8'd0, 4'hF, 4'h9, 1'b1, 4'h5, 4'h1, 1'b0};
    vecs[4] = '{8'd0, 4'h8, 4'h0, 1'b1, 4'hC, 4'h1, 1'b0};
    vecs[5] = '{8'd1, 4'hF, 4'hE, 1'b0, 4'h6, 4'h2, 1'b0};
    vecs[6] = '{8'd0, 4'hF, 4'h9, 1'b0, 4'h5, 4'h1, 1'b1};

    nvec = 0;
    nfail = 0;
    rst = 1'b0;
    in_data = 4'h0;
    arm = 1'b0;
    abort = 1'b0;
    arm0 = 1'b0;
    abort0 = 1'b0;
    div = 8'd0;
    trig_mask = 4'h0;
    trig_value = 4'h0;
    trig_edge = 1'b0;
    ramp = 1'b0;
    rdif.rd_ready = 1'b0;
    rdif0.rd_ready = 1'b0;

    #1 rst = 1'b1;
    #20;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_trig", {31'd0, triggered}, 32'd0);
    chk("rst_valid", {31'd0, rdif.rd_valid}, 32'd0);
    chk("rst_last", {31'd0, rdif.rd_last}, 32'd0);
    chk("rst_data", {28'd0, rdif.rd_data}, 32'd0);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Edge mode with the pattern already present at arm must not fire.
    div = 8'd0; trig_mask = 4'hF; trig_value = 4'h9; trig_edge = 1'b1;
    ramp = 1'b0; in_data = 4'h9;
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (40) tick();
    chk("edge_held_busy", {31'd0, busy}, 32'd1);
    chk("edge_held_trig", {31'd0, triggered}, 32'd0);
    in_data = 4'h3; tick();
    chk("edge_drop_trig", {31'd0, triggered}, 32'd0);
    in_data = 4'h9; tick();
    chk("edge_rise_trig", {31'd0, triggered}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_post_busy", {31'd0, busy}, 32'd0);
    chk("abort_post_trig", {31'd0, triggered}, 32'd0);
    chk("abort_post_valid", {31'd0, rdif.rd_valid}, 32'd0);

    // Abort while waiting, then arm and abort together.
    trig_edge = 1'b0; trig_value = 4'hF; in_data = 4'h0;
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (10) tick();
    chk("wait_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_wait_busy", {31'd0, busy}, 32'd0);
    chk("abort_wait_valid", {31'd0, rdif.rd_valid}, 32'd0);
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    chk("arm_abort_busy", {31'd0, busy}, 32'd0);
    chk("arm_abort_trig", {31'd0, triggered}, 32'd0);

    // Asynchronous reset in the middle of post-trigger capture.
    trig_value = 4'h9; in_data = 4'h0; ramp = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    n = 0;
    while (!triggered && n < 100) begin tick(); n++; end
    chk("post_trig", {31'd0, triggered}, 32'd1);
    tick(); tick();
    chk("post_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_trig", {31'd0, triggered}, 32'd0);
    chk("arst_valid", {31'd0, rdif.rd_valid}, 32'd0);
    tick();
    rst = 1'b0;
    ramp = 1'b0;
    tick();
    run_vec(vecs[0], 7);

    // PRE=0 instance, empty mask: first strobe triggers, arm in READ is ignored.
    div = 8'd0; trig_mask = 4'h0; trig_value = 4'h0; trig_edge = 1'b0;
    in_data = 4'hF; ramp = 1'b1;
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    n = 0;
    while (!rdif0.rd_valid && n < 100) begin tick(); n++; end
    chk("p0_reach_read", {31'd0, rdif0.rd_valid}, 32'd1);
    chk("p0_trig", {31'd0, triggered0}, 32'd1);
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    chk("p0_arm_ign_valid", {31'd0, rdif0.rd_valid}, 32'd1);
    chk("p0_arm_ign_busy", {31'd0, busy0}, 32'd0);
    chk("p0_arm_ign_trig", {31'd0, triggered0}, 32'd1);
    for (int b = 0; b < 16; b++) begin
      rdif0.rd_ready = 1'b1;
      chk($sformatf("p0_data_b%0d", b), {28'd0, rdif0.rd_data}, b);
      chk($sformatf("p0_last_b%0d", b), {31'd0, rdif0.rd_last}, (b == 15) ? 32'd1 : 32'd0);
      tick();
    end
    rdif0.rd_ready = 1'b0;
    ramp = 1'b0;
    chk("p0_end_valid", {31'd0, rdif0.rd_valid}, 32'd0);
    chk("p0_end_data", {28'd0, rdif0.rd_data}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
